fifo_mem_writer: RTL and testbench

FIFO_MEM_WRITER -- requirements
Module: fifo_mem_writer

---
 rtl/fifo_mem_writer.sv | 126 ++++++++++++
 tb/tb_fifo_mem_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_writer.sv
// Drains a first-word-fall-through FIFO, packs BYTES_PER_WORD entries little-endian into one
// memory word and writes it with a we/ready handshake. Define FIFO_MEM_WRITER_PARITY_EN for mem_wpar.
module fifo_mem_writer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned ADDR_WIDTH     = 10
) (
    input  logic                                   clk_mem,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic                                   empty,
    input  logic [DATA_WIDTH-1:0]                  data_out,
    output logic                                   r_en,
    output logic                                   mem_we,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0]   mem_wdata,
    input  logic                                   mem_ready,
    output logic                                   busy,
    output logic [15:0]                            word_count
`ifdef FIFO_MEM_WRITER_PARITY_EN
    ,
    output logic [BYTES_PER_WORD-1:0]              mem_wpar
`endif
);

    localparam int unsigned IdxW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]                               state_q, state_d;
    logic [IdxW-1:0]                          idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]                    addr_q, addr_d;
    logic [15:0]                              count_q, count_d;
    logic [DATA_WIDTH*BYTES_PER_WORD-1:0]     wdata_q;
    logic                                     pop;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        count_d = count_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = FILL;
            end
            FILL: begin
                // A word already started is always finished, even once enable drops.
                if (!enable && idx_q == '0) begin
                    state_d = IDLE;
                end else if (!empty) begin
                    pop = 1'b1;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    state_d = enable ? FILL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            wdata_q <= '0;
        end else begin
            for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                if (pop && idx_q == IdxW'(i)) begin
                    wdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= data_out;
                end
            end
        end
    end

`ifdef FIFO_MEM_WRITER_PARITY_EN
    logic [BYTES_PER_WORD-1:0] wpar_q;

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            wpar_q <= '0;
        end else begin
            for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                if (pop && idx_q == IdxW'(i)) begin
                    wpar_q[i] <= ^data_out;
                end
            end
        end
    end

    assign mem_wpar = wpar_q;
`endif

    assign r_en       = pop;
    assign mem_we     = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_fifo_mem_writer.sv
// Bench for fifo_mem_writer: vector table, hand sequences for reset/enable/latency corners,
// and a randomized 1100-word stream checked against a queue-based FIFO/memory model.
module tb_fifo_mem_writer;

    logic        clk_mem   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic        empty     = 1'b1;
    logic        mem_ready = 1'b1;
    logic [7:0]  data_out  = 8'h00;
    logic        r_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] word_count;
`ifdef FIFO_MEM_WRITER_PARITY_EN
    logic [3:0]  mem_wpar;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] fq[$];
    logic [7:0] popped[$];
    int         acc_cyc[$];
    int         wi = 0, acc_cnt = 0, re_cnt = 0, we_cnt = 0, cyc = 0, rdy_hold = 0;
    bit         gap_mode = 0, rand_hole = 0, rand_rdy = 0, hold_chk = 0;
    logic [9:0]  last_addr = '0, prev_addr = '0;
    logic [31:0] last_data = '0, prev_data = '0;

    typedef struct {
        logic [0:3][7:0] b;
        int              gap;
        int              hold;
        logic [31:0]     exp_data;
        logic [9:0]      exp_addr;
        int              exp_we;
    } vec_t;

    vec_t vt[4];

    fifo_mem_writer dut (
        .clk_mem    (clk_mem),
        .reset_n    (reset_n),
        .enable     (enable),
        .empty      (empty),
        .data_out   (data_out),
        .r_en       (r_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
`ifdef FIFO_MEM_WRITER_PARITY_EN
        .mem_wpar   (mem_wpar),
`endif
        .word_count (word_count)
    );

    always #5 clk_mem = ~clk_mem;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO and memory model: sample at the edge, then drive the next cycle's inputs 1 time unit later.
    always @(posedge clk_mem) begin
        bit          popped_now;
        logic [31:0] w;
        popped_now = 0;
        cyc++;
        if (reset_n) begin
            if (hold_chk) begin
                check("hold_we", 64'(mem_we), 1);
                check("hold_addr", 64'(mem_addr), 64'(prev_addr));
                check("hold_data", 64'(mem_wdata), 64'(prev_data));
            end
            hold_chk = 0;
            if (mem_we) begin
                we_cnt++;
                check("no_pop_in_write", 64'(r_en), 0);
            end
            if (empty) check("no_pop_when_empty", 64'(r_en), 0);
            if (r_en && !empty && fq.size() > 0) begin
                re_cnt++;
                popped.push_back(fq[0]);
                void'(fq.pop_front());
                popped_now = 1;
            end
            if (mem_we && mem_ready) begin
                check("bytes_per_word", 64'(popped.size()), 4);
                w = (popped.size() >= 4) ? {popped[3], popped[2], popped[1], popped[0]} : 32'h0;
                check("wdata", 64'(mem_wdata), 64'(w));
                check("addr", 64'(mem_addr), 64'(wi % 1024));
                check("word_count_pre", 64'(word_count), 64'(wi % 65536));
`ifdef FIFO_MEM_WRITER_PARITY_EN
                check("wpar", 64'(mem_wpar), 64'({^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]}));
`endif
                last_addr = mem_addr;
                last_data = mem_wdata;
                acc_cyc.push_back(cyc);
                wi++;
                acc_cnt++;
                popped.delete();
            end else if (mem_we) begin
                hold_chk  = 1;
                prev_addr = mem_addr;
                prev_data = mem_wdata;
            end
        end
        #1;
        if (mem_we && rdy_hold > 0) begin
            mem_ready = 1'b0;
            rdy_hold--;
        end else begin
            mem_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        empty    = (gap_mode && popped_now) || (rand_hole && $urandom_range(0, 2) == 0)
                   || fq.size() == 0;
        data_out = (fq.size() > 0) ? fq[0] : 8'h00;
    end

    task automatic wait_acc(input int target, input int budget, input string name);
        int k = 0;
        while (acc_cnt < target && k < budget) begin
            @(negedge clk_mem);
            k++;
        end
        check(name, 64'(acc_cnt >= target), 1);
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k = 0;
        while (popped.size() < n && k < budget) begin
            @(negedge clk_mem);
            k++;
        end
        check("pop_wait", 64'(popped.size() >= n), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_mem);
        reset_n = 1'b0;
        #1;
        check("rst_r_en", 64'(r_en), 0);
        check("rst_mem_we", 64'(mem_we), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_addr", 64'(mem_addr), 0);
        check("rst_wdata", 64'(mem_wdata), 0);
        check("rst_word_count", 64'(word_count), 0);
`ifdef FIFO_MEM_WRITER_PARITY_EN
        check("rst_wpar", 64'(mem_wpar), 0);
`endif
        popped.delete();
        fq.delete();
        empty    = 1'b1;
        wi       = 0;
        hold_chk = 0;
        rdy_hold = 0;
        repeat (2) @(negedge clk_mem);
        reset_n = 1'b1;
    endtask

    initial begin
        int start, n0;
        vt[0] = '{b: {8'h11, 8'h22, 8'h33, 8'h44}, gap: 0, hold: 0,
                  exp_data: 32'h44332211, exp_addr: 10'd0, exp_we: 1};
        vt[1] = '{b: {8'hAA, 8'hBB, 8'hCC, 8'hDD}, gap: 1, hold: 0,
                  exp_data: 32'hDDCCBBAA, exp_addr: 10'd1, exp_we: 1};
        vt[2] = '{b: {8'h01, 8'h02, 8'h03, 8'h04}, gap: 0, hold: 5,
                  exp_data: 32'h04030201, exp_addr: 10'd2, exp_we: 6};
        vt[3] = '{b: {8'hFE, 8'h00, 8'h80, 8'h7F}, gap: 1, hold: 2,
                  exp_data: 32'h7F8000FE, exp_addr: 10'd3, exp_we: 3};

        do_reset();
        enable = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk_mem);
            re_cnt   = 0;
            we_cnt   = 0;
            gap_mode = (vt[i].gap != 0);
            rdy_hold = vt[i].hold;
            start    = acc_cnt;
            for (int j = 0; j < 4; j++) fq.push_back(vt[i].b[j]);
            wait_acc(start + 1, 200, "vec_timeout");
            check("vec_wdata", 64'(last_data), 64'(vt[i].exp_data));
            check("vec_addr", 64'(last_addr), 64'(vt[i].exp_addr));
            check("vec_r_en_cycles", 64'(re_cnt), 4);
            check("vec_we_cycles", 64'(we_cnt), 64'(vt[i].exp_we));
            check("vec_word_count", 64'(word_count), 64'(i + 1));
        end
        gap_mode = 0;

        // Back-to-back words from a full FIFO: one word every 5 cycles.
        @(negedge clk_mem);
        start = acc_cnt;
        n0    = acc_cyc.size();
        for (int j = 0; j < 12; j++) fq.push_back(8'(j * 17 + 3));
        wait_acc(start + 3, 200, "lat_timeout");
        if (acc_cyc.size() >= n0 + 3) begin
            check("lat_gap1", 64'(acc_cyc[n0+1] - acc_cyc[n0]), 5);
            check("lat_gap2", 64'(acc_cyc[n0+2] - acc_cyc[n0+1]), 5);
        end

        // Enable dropped mid-word: word completes, then IDLE, remaining entries untouched.
        @(negedge clk_mem);
        start = acc_cnt;
        for (int j = 0; j < 8; j++) fq.push_back(8'(8'h30 + j));
        wait_pops(2, 100);
        enable = 1'b0;
        wait_acc(start + 1, 100, "drop_timeout");
        repeat (3) @(negedge clk_mem);
        check("drop_busy", 64'(busy), 0);
        check("drop_mem_we", 64'(mem_we), 0);
        check("drop_fifo_left", 64'(fq.size()), 4);
        check("drop_wdata", 64'(last_data), 32'h33323130);

        // Reset after three bytes: partial word is discarded, restart at address 0.
        fq.delete();
        empty = 1'b1;
        @(negedge clk_mem);
        enable = 1'b1;
        fq.push_back(8'h55); fq.push_back(8'h66); fq.push_back(8'h77); fq.push_back(8'h88);
        wait_pops(3, 100);
        do_reset();
        start = acc_cnt;
        fq.push_back(8'h00); fq.push_back(8'h07); fq.push_back(8'h03); fq.push_back(8'h01);
        wait_acc(start + 1, 100, "postrst_timeout");
        check("postrst_wdata", 64'(last_data), 32'h01030700);
        check("postrst_addr", 64'(last_addr), 0);
`ifdef FIFO_MEM_WRITER_PARITY_EN
        check("postrst_wpar", 64'(mem_wpar), 4'b1010);
`endif

        // Randomized stream long enough to wrap the address.
        do_reset();
        rand_hole = 1;
        rand_rdy  = 1;
        start     = acc_cnt;
        for (int j = 0; j < 4400; j++) fq.push_back(8'($urandom));
        wait_acc(start + 1100, 40000, "stream_timeout");
        @(negedge clk_mem);
        check("stream_word_count", 64'(word_count), 1100);
        check("stream_addr", 64'(mem_addr), 76);
        check("stream_drained", 64'(fq.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
